// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, memory command codes and tag-owner encoding
package mem_arbiter_pkg;

   localparam int ADDR_W      = 32;
   localparam int MEM_BLOCK_W = 64;
   localparam int MEM_TAG_W   = 4;
   localparam int MEM_CMD_W   = 2;

   localparam logic [MEM_CMD_W-1:0] MEM_NONE  = 2'h0;
   localparam logic [MEM_CMD_W-1:0] MEM_LOAD  = 2'h1;
   localparam logic [MEM_CMD_W-1:0] MEM_STORE = 2'h2;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'h0,
      OWNER_I    = 2'h1,
      OWNER_D    = 2'h2
   } mem_owner_e;

   localparam int STARVE_LIMIT_DEFAULT = 4;
   localparam int NUM_MEM_TAG_ENTRIES  = 16;

   function automatic logic [1:0] owner_of_grant(input logic grant_d);
      return grant_d ? OWNER_D : OWNER_I;
   endfunction

endpackage

// File: rtl/mem_tag_table.sv
// rtl/mem_tag_table.sv - per-tag owner register file with allocate, clear and one read port
module mem_tag_table
   import mem_arbiter_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 alloc_en_i,
   input  logic [MEM_TAG_W-1:0] alloc_idx_i,
   input  logic [1:0]           alloc_owner_i,
   input  logic                 clr_en_i,
   input  logic [MEM_TAG_W-1:0] clr_idx_i,
   input  logic [MEM_TAG_W-1:0] rd_idx_i,
   output logic [1:0]           rd_owner_o
`ifdef CPU_DEBUG_OUT
   ,
   output logic [NUM_MEM_TAG_ENTRIES-1:0][1:0] owners_o
`endif
);

   logic [1:0] owner_q [NUM_MEM_TAG_ENTRIES];
   logic [1:0] owner_d [NUM_MEM_TAG_ENTRIES];

   // Clear is applied before allocate so a tag returned and reissued in the same cycle keeps its new owner.
   always_comb begin
      for (int i = 0; i < NUM_MEM_TAG_ENTRIES; i++) begin
         owner_d[i] = owner_q[i];
         if (clr_en_i && clr_idx_i == MEM_TAG_W'(i)) begin
            owner_d[i] = OWNER_NONE;
         end
         if (alloc_en_i && alloc_idx_i == MEM_TAG_W'(i)) begin
            owner_d[i] = alloc_owner_i;
         end
      end
      owner_d[0] = OWNER_NONE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_MEM_TAG_ENTRIES; i++) begin
            owner_q[i] <= OWNER_NONE;
         end
      end else begin
         owner_q <= owner_d;
      end
   end

   assign rd_owner_o = owner_q[rd_idx_i];

`ifdef CPU_DEBUG_OUT
   always_comb begin
      for (int i = 0; i < NUM_MEM_TAG_ENTRIES; i++) begin
         owners_o[i] = owner_q[i];
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for the single memory port with tag-owner return routing
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [MEM_CMD_W-1:0]   icache2mem_command_i,
   input  logic [ADDR_W-1:0]      icache2mem_addr_i,
   input  logic [MEM_CMD_W-1:0]   dcache2mem_command_i,
   input  logic [ADDR_W-1:0]      dcache2mem_addr_i,
   input  logic [MEM_BLOCK_W-1:0] dcache2mem_data_i,
   input  logic [MEM_TAG_W-1:0]   mem2proc_transaction_tag_i,
   input  logic [MEM_BLOCK_W-1:0] mem2proc_data_i,
   input  logic [MEM_TAG_W-1:0]   mem2proc_data_tag_i,
   output logic [MEM_CMD_W-1:0]   proc2mem_command_o,
   output logic [ADDR_W-1:0]      proc2mem_addr_o,
   output logic [MEM_BLOCK_W-1:0] proc2mem_data_o,
   output logic                   dcache_request_o,
   output logic [MEM_TAG_W-1:0]   imem2proc_transaction_tag_o,
   output logic [MEM_TAG_W-1:0]   dmem2proc_transaction_tag_o,
   output logic [MEM_BLOCK_W-1:0] imem2proc_data_o,
   output logic [MEM_BLOCK_W-1:0] dmem2proc_data_o,
   output logic [MEM_TAG_W-1:0]   imem2proc_data_tag_o,
   output logic [MEM_TAG_W-1:0]   dmem2proc_data_tag_o
`ifdef CPU_DEBUG_OUT
   ,
   output logic [NUM_MEM_TAG_ENTRIES-1:0][1:0] tag_owner_debug_o
`endif
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             i_req, d_req;
   logic             grant_i, grant_d;
   logic             d_is_load;
   logic             alloc_en;
   logic             clr_en;
   logic [1:0]       rd_owner;

   assign i_req     = (icache2mem_command_i != MEM_NONE);
   assign d_req     = (dcache2mem_command_i != MEM_NONE);
   assign d_is_load = (dcache2mem_command_i == MEM_LOAD);

   // The dcache normally wins a tie; a starved icache takes exactly one cycle back.
   assign grant_d = d_req && !(i_req && starve_q == STARVE_MAX);
   assign grant_i = i_req && !grant_d;

   always_comb begin
      proc2mem_command_o = MEM_NONE;
      proc2mem_addr_o    = '0;
      proc2mem_data_o    = '0;
      if (grant_d) begin
         proc2mem_command_o = dcache2mem_command_i;
         proc2mem_addr_o    = dcache2mem_addr_i;
         if (dcache2mem_command_i == MEM_STORE) begin
            proc2mem_data_o = dcache2mem_data_i;
         end
      end else if (grant_i) begin
         proc2mem_command_o = icache2mem_command_i;
         proc2mem_addr_o    = icache2mem_addr_i;
      end
   end

   assign dcache_request_o = grant_d;

   // Stores get no tag back to the dcache; only accepted loads are announced.
   assign imem2proc_transaction_tag_o = grant_i ? mem2proc_transaction_tag_i : '0;
   assign dmem2proc_transaction_tag_o = (grant_d && d_is_load) ? mem2proc_transaction_tag_i : '0;

   always_comb begin
      starve_d = '0;
      if (i_req && !grant_i) begin
         starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign alloc_en = (grant_i || (grant_d && d_is_load)) && (mem2proc_transaction_tag_i != '0);
   assign clr_en   = (mem2proc_data_tag_i != '0);

   mem_tag_table u_tag_table (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .alloc_en_i    (alloc_en),
      .alloc_idx_i   (mem2proc_transaction_tag_i),
      .alloc_owner_i (owner_of_grant(grant_d)),
      .clr_en_i      (clr_en),
      .clr_idx_i     (mem2proc_data_tag_i),
      .rd_idx_i      (mem2proc_data_tag_i),
      .rd_owner_o    (rd_owner)
`ifdef CPU_DEBUG_OUT
      ,
      .owners_o      (tag_owner_debug_o)
`endif
   );

   assign imem2proc_data_o     = mem2proc_data_i;
   assign dmem2proc_data_o     = mem2proc_data_i;
   assign imem2proc_data_tag_o = (rd_owner == OWNER_I) ? mem2proc_data_tag_i : '0;
   assign dmem2proc_data_tag_o = (rd_owner == OWNER_D) ? mem2proc_data_tag_i : '0;

endmodule
